ps2_keycode_receiver: RTL and testbench
=======================================

# ps2_keycode_receiver

Parametrised PS/2 keyboard receiver that replaces the free-running, PS2_CLK-clocked key decoder. Both PS/2 lines are synchronised into the system clock domain. Each 11-bit frame is checked for start, odd parity and stop bits, and an inter-bit timeout recovers a stalled frame. E0/F0 prefixes are folded into one decoded key event, and events are queued in a first-word-fall-through FIFO read by the game controller and datapath.

## Interface
- FIFO_DEPTH, 4: event FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 50000: clk cycles allowed between PS/2 falling edges inside a frame (1 ms at 50 MHz); ≥16.
- SYNC_STAGES, 2: synchroniser flops per PS/2 line; ≥2.
- clk  in  1  system clock (CLOCK_50 at top level).
- resetn  in  1  reset, asynchronous and active-low.
- ps2_clk  in  1  raw PS2_CLK pin.
- ps2_dat  in  1  raw PS2_DAT pin.
- rd_en  in  1  pop head FIFO entry; ignored when empty.
- key_valid  out  1  FIFO non-empty.
- key_code  out  8  head entry scan code (final byte, prefixes stripped).
- key_break  out  1  head entry preceded by F0 (key release).
- key_ext  out  1  head entry preceded by E0 (extended key, e.g. arrows).
- frame_err  out  1  one-cycle pulse: bad start/parity/stop or timeout.
- overflow  out  1  one-cycle pulse: event dropped, FIFO full.
- count  out  $clog2(FIFO_DEPTH+1)  entries held.

## Operation
- Synchroniser flops reset to 1 (idle bus), so no edge is seen out of reset. Falling edge = previous synced ps2_clk 1, current 0. Data is sampled from synced ps2_dat on that cycle.
- FSM states: IDLE, RECV.
  - IDLE: a falling edge with data 0 sets bit_cnt=0 and goes to RECV. A falling edge with data 1 is ignored and gives no error.
  - RECV: bits 0-7 shift into the byte LSB first, bit 8 is parity, bit 9 is stop. On the stop edge the FSM returns to IDLE.
  - Frame is good when XOR of the 8 data bits and parity is 1, and stop is 1. Otherwise frame_err pulses, the byte is discarded, and both prefix flags clear.
- Timeout: a counter clears on every falling edge and counts only in RECV. On reaching TIMEOUT_CYCLES: frame_err pulse, go to IDLE, prefix flags clear.
- Decode of a good byte:
  - E0 sets ext_pend.
  - F0 sets brk_pend.
  - Any other byte pushes {ext_pend, brk_pend, byte} and clears both flags.
  - Repeated prefixes are idempotent.
- FIFO:
  - Push when full drops the new event and pulses overflow; contents are unchanged.
  - Simultaneous push and pop: both take effect, count unchanged; this holds when full too, with no overflow.
  - rd_en when empty: no effect.
  - Outputs always show the head entry, FWFT. When empty, key_code/key_break/key_ext hold 0.
- Pointer wrap is modulo FIFO_DEPTH. count is the true occupancy, 0..FIFO_DEPTH.

## Timing
- Reset (resetn low, async): all outputs 0, FIFO empty, FSM IDLE, bit_cnt 0, flags 0, timeout 0, sync flops 1.
- resetn asserted mid-frame aborts the frame without a frame_err pulse.
- Input latency: SYNC_STAGES+1 clk from pin edge to edge detect.
- Let E be the clk edge on which the stop-bit falling edge is detected.
  - Push registers at E+1; key_valid/count update visible after E+1.
  - frame_err and overflow pulse in the cycle after E, high exactly 1 clk.
- Pop: rd_en sampled at edge P; next entry (or empty) visible after P.
- A timeout fires exactly TIMEOUT_CYCLES clk after the last falling edge while in RECV.
- PS/2 clock is 10-16.7 kHz, so at least ~3000 clk separate edges; the decoder completes well before the next frame.

## Test plan
- Make 0x1C (data LSB first, parity 0, stop 1) → key_valid=1, key_code=1C, key_break=0, key_ext=0, count=1. rd_en 1 cycle → key_valid=0, key_code=00.
- E0, F0, 75 (parities 0,1,0) → one entry: key_code=75, key_ext=1, key_break=1. Next frame 6B → key_code=6B, key_ext=0, key_break=0.
- Frame 75 with parity 1, then a good 72 → frame_err pulses once, no push; then exactly one entry 72.
- 4 start + 3 data bits then bus idle → frame_err exactly 50000 clk after the last edge; FSM back to IDLE; a following good 74 is queued correctly.
- FIFO_DEPTH=4: push 5 keys with no reads → count=4, overflow pulses on the 5th; reads return keys 1-4 in order. With full FIFO, hold rd_en during the next push → count stays 4, no overflow.
- resetn low mid-frame (after 5 bits), release, send 75 → no frame_err, single entry 75; all outputs 0 while in reset.

Source files
------------

// File: rtl/ps2_keycode_receiver.sv
// PS/2 keyboard receiver: synchronised pins, frame check with inter-bit timeout, E0/F0 folding, FWFT event queue.
// Event visible 2 clk after the stop-bit edge is detected; no backpressure, an event arriving at a full queue is dropped with an overflow pulse.
module ps2_keycode_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_vld,
  output logic          wr_rdy,
  input  logic [W-1:0]  wr_dat,
  output logic          rd_vld,
  input  logic          rd_rdy,
  output logic [W-1:0]  rd_dat,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_wr, do_rd;

  // A pop in the same cycle frees a slot, so a full queue still accepts a write.
  always_comb begin
    rd_vld   = (cnt_q != '0);
    do_rd    = rd_vld && rd_rdy;
    wr_rdy   = (cnt_q != CW'(DEPTH)) || do_rd;
    do_wr    = wr_vld && wr_rdy;
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    cnt_d    = cnt_q + CW'(do_wr) - CW'(do_rd);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
  end

  assign rd_dat = mem_q[rd_ptr_q];
  assign count  = cnt_q;
endmodule

module ps2_keycode_receiver #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               ps2_clk,
  input  logic                               ps2_dat,
  input  logic                               rd_en,
  output logic                               key_valid,
  output logic [7:0]                         key_code,
  output logic                               key_break,
  output logic                               key_ext,
  output logic                               frame_err,
  output logic                               overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  typedef enum logic {IDLE, RECV} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   fall, bit_dat;

  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;
  logic          frame_err_q, frame_err_d;
  logic          evt_vld_q, evt_vld_d;
  key_evt_t      evt_q, evt_d;

  key_evt_t      head;
  logic          fifo_wr_rdy, fifo_rd_vld;

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
    clk_prev_d = clk_sync_q[SYNC_STAGES-1];
    fall       = clk_prev_q && !clk_sync_q[SYNC_STAGES-1];
    bit_dat    = dat_sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    frame_err_d = 1'b0;
    evt_vld_d   = 1'b0;
    evt_d       = evt_q;
    to_cnt_d    = (state_q == RECV) ? to_cnt_q + TW'(1) : to_cnt_q;

    if (fall) begin
      to_cnt_d = '0;
      if (state_q == IDLE) begin
        if (!bit_dat) begin
          state_d   = RECV;
          bit_cnt_d = '0;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q < 4'd8) begin
          shift_d = {bit_dat, shift_q[7:1]};
        end else if (bit_cnt_q == 4'd8) begin
          par_d = bit_dat;
        end else begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          // Odd parity over data plus parity bit, and a high stop bit.
          if ((^{shift_q, par_q}) && bit_dat) begin
            if (shift_q == 8'hE0) begin
              ext_pend_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_pend_d = 1'b1;
            end else begin
              evt_vld_d  = 1'b1;
              evt_d.ext  = ext_pend_q;
              evt_d.brk  = brk_pend_q;
              evt_d.code = shift_q;
              ext_pend_d = 1'b0;
              brk_pend_d = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
          end
        end
      end
    end else if (state_q == RECV && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      to_cnt_d    = '0;
      frame_err_d = 1'b1;
      ext_pend_d  = 1'b0;
      brk_pend_d  = 1'b0;
    end
  end

  // Synchroniser flops reset high so an idle bus produces no edge after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q  <= '1;
      dat_sync_q  <= '1;
      clk_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      frame_err_q <= 1'b0;
      evt_vld_q   <= 1'b0;
      evt_q       <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      frame_err_q <= frame_err_d;
      evt_vld_q   <= evt_vld_d;
      evt_q       <= evt_d;
    end
  end

  ps2_keycode_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(key_evt_t))
  ) u_evt_fifo (
    .clk    (clk),
    .resetn (resetn),
    .wr_vld (evt_vld_q),
    .wr_rdy (fifo_wr_rdy),
    .wr_dat (evt_q),
    .rd_vld (fifo_rd_vld),
    .rd_rdy (rd_en),
    .rd_dat (head),
    .count  (count)
  );

  assign key_valid = fifo_rd_vld;
  assign key_code  = fifo_rd_vld ? head.code : 8'h00;
  assign key_break = fifo_rd_vld && head.brk;
  assign key_ext   = fifo_rd_vld && head.ext;
  assign frame_err = frame_err_q;
  assign overflow  = evt_vld_q && !fifo_wr_rdy;
endmodule

// File: tb/tb_ps2_keycode_receiver.sv
// Bench for ps2_keycode_receiver: frame-level reference model checked every cycle, plus directed literal checks.
module tb_ps2_keycode_receiver;
  localparam int DEPTH = 4;
  localparam int TMO   = 50000;
  localparam int SYNC  = 2;
  localparam int HALF  = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          resetn, ps2_clk, ps2_dat, rd_en;
  logic          key_valid, key_break, key_ext, frame_err, overflow;
  logic [7:0]    key_code;
  logic [CW-1:0] count;

  int checks = 0, errors = 0, cyc = 0;
  int ferr_pulses = 0, ovf_pulses = 0;
  int last_drive = 0;

  // Model: pin falls become visible SYNC+1 clk later; frames are decoded whole.
  int       fall_due_q[$];
  bit       fall_dat_q[$];
  bit [9:0] mq[$];
  bit       m_inframe = 0, m_ext = 0, m_brk = 0;
  int       m_nbits = 0, m_last_fall = 0;
  bit [9:0] m_bits;
  int       m_ferr_cyc = -100, m_push_due = -100;
  bit [9:0] m_push_evt;

  bit       ev;
  bit [9:0] hd;
  bit [7:0] keys [5];

  ps2_keycode_receiver #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .rd_en     (rd_en),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_break (key_break),
    .key_ext   (key_ext),
    .frame_err (frame_err),
    .overflow  (overflow),
    .count     (count)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    bit was_full, popped, d;
    bit [7:0] b;
    cyc++;
    if (!resetn) begin
      mq.delete();
      fall_due_q.delete();
      fall_dat_q.delete();
      m_inframe  = 0;
      m_ext      = 0;
      m_brk      = 0;
      m_ferr_cyc = -100;
      m_push_due = -100;
    end else begin
      was_full = (mq.size() == DEPTH);
      popped   = 0;
      if (rd_en && mq.size() > 0) begin
        void'(mq.pop_front());
        popped = 1;
      end
      if (m_push_due == cyc && (!was_full || popped)) mq.push_back(m_push_evt);

      if (fall_due_q.size() > 0 && fall_due_q[0] == cyc) begin
        void'(fall_due_q.pop_front());
        d = fall_dat_q.pop_front();
        m_last_fall = cyc;
        if (!m_inframe) begin
          if (!d) begin
            m_inframe = 1;
            m_nbits   = 0;
          end
        end else begin
          m_bits[m_nbits] = d;
          m_nbits++;
          if (m_nbits == 10) begin
            m_inframe = 0;
            b = m_bits[7:0];
            if ((^m_bits[8:0]) && m_bits[9]) begin
              if (b == 8'hE0) m_ext = 1;
              else if (b == 8'hF0) m_brk = 1;
              else begin
                m_push_evt = {m_ext, m_brk, b};
                m_push_due = cyc + 1;
                m_ext = 0;
                m_brk = 0;
              end
            end else begin
              m_ferr_cyc = cyc;
              m_ext = 0;
              m_brk = 0;
            end
          end
        end
      end else if (m_inframe && cyc - m_last_fall == TMO) begin
        m_inframe  = 0;
        m_ferr_cyc = cyc;
        m_ext = 0;
        m_brk = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (frame_err) ferr_pulses++;
    if (overflow) ovf_pulses++;
    if (!resetn) begin
      chk("rst_valid", key_valid, 0);
      chk("rst_code", key_code, 0);
      chk("rst_brk", key_break, 0);
      chk("rst_ext", key_ext, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_count", count, 0);
    end else begin
      ev = (mq.size() > 0);
      hd = ev ? mq[0] : 10'd0;
      chk("valid", key_valid, int'(ev));
      chk("code", key_code, int'(hd[7:0]));
      chk("brk", key_break, int'(hd[8]));
      chk("ext", key_ext, int'(hd[9]));
      chk("count", count, mq.size());
      chk("frame_err", frame_err, int'(m_ferr_cyc == cyc));
      chk("overflow", overflow,
          int'(m_push_due == cyc + 1 && mq.size() == DEPTH && !rd_en));
    end
  end

  task automatic send_bit(input logic b, input bit pop_on_push);
    ps2_dat = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    fall_due_q.push_back(cyc + SYNC + 1);
    fall_dat_q.push_back(b);
    last_drive = cyc;
    if (pop_on_push) begin
      repeat (SYNC + 1) @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      repeat (HALF - SYNC - 2) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_on_push);
    send_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 0);
    send_bit((~^b) ^ bad_par, 0);
    send_bit(1'b1, pop_on_push);
    ps2_dat = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    int f0, o0, target;
    keys = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    rd_en   = 1'b0;
    resetn  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", key_valid, 0);
    chk("reset_count", count, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    send_frame(8'h1C, 0, 0);
    chk("make_valid", key_valid, 1);
    chk("make_code", key_code, 8'h1C);
    chk("make_brk", key_break, 0);
    chk("make_ext", key_ext, 0);
    chk("make_count", count, 1);
    pop1();
    chk("pop_valid", key_valid, 0);
    chk("pop_code", key_code, 8'h00);

    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    chk("prefix_count", count, 1);
    chk("prefix_code", key_code, 8'h75);
    chk("prefix_ext", key_ext, 1);
    chk("prefix_brk", key_break, 1);
    pop1();
    send_frame(8'h6B, 0, 0);
    chk("plain_code", key_code, 8'h6B);
    chk("plain_ext", key_ext, 0);
    chk("plain_brk", key_break, 0);
    pop1();

    f0 = ferr_pulses;
    send_frame(8'h75, 1, 0);
    send_frame(8'h72, 0, 0);
    chk("parity_err_pulses", ferr_pulses - f0, 1);
    chk("parity_count", count, 1);
    chk("parity_code", key_code, 8'h72);
    pop1();

    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    ps2_dat = 1'b1;
    target = last_drive + SYNC + 1 + TMO;
    while (cyc < target - 1) @(negedge clk);
    chk("timeout_early", frame_err, 0);
    @(negedge clk);
    chk("timeout_fire", frame_err, 1);
    repeat (4) @(negedge clk);
    send_frame(8'h74, 0, 0);
    chk("after_tmo_code", key_code, 8'h74);
    chk("after_tmo_count", count, 1);
    pop1();

    o0 = ovf_pulses;
    for (int i = 0; i < 5; i++) send_frame(keys[i], 0, 0);
    chk("full_count", count, DEPTH);
    chk("ovf_pulses", ovf_pulses - o0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_code", key_code, int'(keys[i]));
      pop1();
    end
    chk("drained_valid", key_valid, 0);
    for (int i = 0; i < 4; i++) send_frame(keys[i], 0, 0);
    o0 = ovf_pulses;
    send_frame(keys[4], 0, 1);
    chk("pushpop_count", count, DEPTH);
    chk("pushpop_ovf", ovf_pulses - o0, 0);
    chk("pushpop_head", key_code, 8'h1D);

    f0 = ferr_pulses;
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("inreset_valid", key_valid, 0);
    chk("inreset_count", count, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h75, 0, 0);
    chk("midreset_ferr", ferr_pulses - f0, 0);
    chk("midreset_count", count, 1);
    chk("midreset_code", key_code, 8'h75);

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
